// File: rtl/ahbl_spi_xip.sv
// AHB-Lite read-only execute-in-place bridge to a SPI NOR flash (READ 0x03, mode 0).
// Keeps a one-word buffer; misses stall the bus while the word is fetched serially.
module ahbl_spi_xip #(
   parameter int CLK_DIV = 2,
   parameter int CS_GAP  = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ahbl_hsel_i,
   input  logic [31:0] ahbl_haddr_i,
   input  logic [1:0]  ahbl_htrans_i,
   input  logic        ahbl_hwrite_i,
   input  logic [2:0]  ahbl_hsize_i,
   input  logic        ahbl_hready_i,
   output logic        ahbl_hreadyout_o,
   output logic        ahbl_hresp_o,
   output logic [31:0] ahbl_hrdata_o,
   input  logic        flush_i,
   output logic        spi_cs_o,
   output logic        spi_clk_o,
   output logic        spi_mosi_o,
   input  logic        spi_miso_i
);

   typedef enum logic [2:0] {IDLE, GAP, CMD, ADDR, DATA, DONE, ERR1, ERR2} state_t;

   localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_SAT = 8'(CS_GAP);

   state_t      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [7:0]  gap_q, gap_d;
   logic [5:0]  bit_q, bit_d;
   logic        sclk_q, sclk_d;
   logic [31:0] tx_q, tx_d;
   logic [31:0] rx_q, rx_d;
   logic [31:0] hrdata_q, hrdata_d;
   logic [31:0] bufData_q, bufData_d;
   logic [21:0] bufTag_q, bufTag_d;
   logic [21:0] pendTag_q, pendTag_d;
   logic        bufValid_q, bufValid_d;

   logic        accept, busy, hit, gapMet;
   logic [31:0] rxWord;
   logic        unused_ok;

   assign accept = ahbl_hsel_i & ahbl_hready_i & ahbl_htrans_i[1];
   assign busy   = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
   assign hit    = bufValid_q & (bufTag_q == ahbl_haddr_i[23:2]) & ~flush_i;
   assign gapMet = (gap_q >= GAP_SAT);
   // Flash bytes arrive first-byte-first; the first byte lands in the low lane.
   assign rxWord = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};

   assign unused_ok = ^{ahbl_haddr_i[31:24], ahbl_haddr_i[1:0], ahbl_hsize_i, ahbl_htrans_i[0]};

   assign ahbl_hreadyout_o = ~(busy || (state_q == GAP) || (state_q == ERR1));
   assign ahbl_hresp_o     = (state_q == ERR1) || (state_q == ERR2);
   assign ahbl_hrdata_o    = hrdata_q;
   assign spi_cs_o         = ~busy;
   assign spi_clk_o        = sclk_q;
   assign spi_mosi_o       = busy & tx_q[31];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         div_q      <= '0;
         gap_q      <= GAP_SAT;
         bit_q      <= '0;
         sclk_q     <= 1'b0;
         tx_q       <= '0;
         rx_q       <= '0;
         hrdata_q   <= '0;
         bufData_q  <= '0;
         bufTag_q   <= '0;
         pendTag_q  <= '0;
         bufValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         gap_q      <= gap_d;
         bit_q      <= bit_d;
         sclk_q     <= sclk_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         hrdata_q   <= hrdata_d;
         bufData_q  <= bufData_d;
         bufTag_q   <= bufTag_d;
         pendTag_q  <= pendTag_d;
         bufValid_q <= bufValid_d;
      end
   end

   // gap_q counts completed chip-select-high cycles, saturating at CS_GAP.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      sclk_d     = sclk_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      hrdata_d   = hrdata_q;
      bufData_d  = bufData_q;
      bufTag_d   = bufTag_q;
      pendTag_d  = pendTag_q;
      bufValid_d = bufValid_q & ~flush_i;
      gap_d      = busy ? 8'd0 : (gapMet ? GAP_SAT : gap_q + 8'd1);

      case (state_q)
         IDLE, DONE, ERR2: begin
            state_d = IDLE;
            div_d   = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
            if (accept) begin
               if (ahbl_hwrite_i) begin
                  state_d = ERR1;
               end else if (hit) begin
                  hrdata_d = bufData_q;
               end else begin
                  pendTag_d = ahbl_haddr_i[23:2];
                  tx_d      = {8'h03, ahbl_haddr_i[23:2], 2'b00};
                  state_d   = gapMet ? CMD : GAP;
               end
            end
         end
         ERR1: state_d = ERR2;
         GAP: begin
            if (gapMet) begin
               state_d = CMD;
            end
         end
         CMD, ADDR, DATA: begin
            if (div_q == DIV_MAX) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  rx_d = {rx_q[30:0], spi_miso_i};
               end else begin
                  // Falling edge closes a bit: advance MOSI while SCK is low.
                  bit_d = bit_q + 6'd1;
                  tx_d  = {tx_q[30:0], 1'b0};
                  if (bit_q == 6'd7) begin
                     state_d = ADDR;
                  end else if (bit_q == 6'd31) begin
                     state_d = DATA;
                  end else if (bit_q == 6'd63) begin
                     state_d    = DONE;
                     hrdata_d   = rxWord;
                     bufData_d  = rxWord;
                     bufTag_d   = pendTag_q;
                     bufValid_d = 1'b1;
                  end
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ahbl_spi_xip.sv
// Self-checking bench for ahbl_spi_xip: transaction-level model plus a serial flash model.
// The flash only decodes address bits [7:0]; contents alias every 256 bytes.
module tb_ahbl_spi_xip;

   localparam int CLK_DIV = 2;
   localparam int CS_GAP  = 2;
   localparam int XFER    = 128 * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst;
   logic        hsel, hwrite, flush;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hreadyout, hresp;
   logic [31:0] hrdata;
   logic        cs, sclk, mosi;
   logic        miso = 1'b0;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   ahbl_spi_xip #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
      .clk_i(clk), .rst_i(rst),
      .ahbl_hsel_i(hsel), .ahbl_haddr_i(haddr), .ahbl_htrans_i(htrans),
      .ahbl_hwrite_i(hwrite), .ahbl_hsize_i(hsize), .ahbl_hready_i(hreadyout),
      .ahbl_hreadyout_o(hreadyout), .ahbl_hresp_o(hresp), .ahbl_hrdata_o(hrdata),
      .flush_i(flush),
      .spi_cs_o(cs), .spi_clk_o(sclk), .spi_mosi_o(mosi), .spi_miso_i(miso)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Serial flash: collects 32 command/address bits, then shifts data out on SCK falling edges.
   logic [7:0]  flashMem [0:255];
   logic [31:0] fCmd = '0;
   int          fBits = 0;
   int          fk;
   int          sclkEdges = 0;

   always @(negedge cs or posedge sclk) begin
      if (!sclk) begin
         fBits = 0;
      end else if (!cs) begin
         if (fBits < 32) fCmd = {fCmd[30:0], mosi};
         fBits++;
      end
   end

   always @(negedge sclk) begin
      if (!cs && fBits >= 32 && fBits < 64) begin
         fk   = fBits - 32;
         miso = flashMem[8'(fCmd[7:0] + 8'(fk / 8))][7 - (fk % 8)];
      end
   end

   always @(posedge sclk) sclkEdges++;

   function automatic logic [31:0] wordAt(input logic [21:0] tag);
      logic [7:0] b;
      b = {tag[5:0], 2'b00};
      return {flashMem[b + 8'd3], flashMem[b + 8'd2], flashMem[b + 8'd1], flashMem[b]};
   endfunction

   // Transaction-level model: remaining stall cycles, error phase, buffer contents, CS-high history.
   int          waitLeft, errPhase, hc;
   logic        mValid;
   logic [21:0] mTag, pendTag;
   logic [31:0] expData;
   logic        expReady, expResp, expCs;
   logic        completing;

   always @(posedge clk) begin
      if (rst) begin
         waitLeft = 0;
         errPhase = 0;
         hc       = 1000;
         mValid   = 1'b0;
         mTag     = '0;
         pendTag  = '0;
         expData  = '0;
      end else begin
         hc         = expCs ? ((hc < 1000) ? hc + 1 : hc) : 0;
         completing = 1'b0;
         if (waitLeft > 0) begin
            waitLeft--;
            completing = (waitLeft == 0);
         end else if (errPhase == 1) begin
            errPhase = 2;
         end else begin
            errPhase = 0;
            if (hsel && htrans[1]) begin
               if (hwrite) begin
                  errPhase = 1;
               end else if (mValid && mTag == haddr[23:2] && !flush) begin
                  expData = wordAt(haddr[23:2]);
               end else begin
                  pendTag  = haddr[23:2];
                  waitLeft = XFER + ((hc >= CS_GAP + 1) ? 0 : CS_GAP + 1 - hc);
               end
            end
         end
         if (flush) mValid = 1'b0;
         if (completing) begin
            mValid  = 1'b1;
            mTag    = pendTag;
            expData = wordAt(pendTag);
         end
      end
      expReady = (waitLeft == 0) && (errPhase != 1);
      expResp  = (errPhase != 0);
      expCs    = !(waitLeft >= 1 && waitLeft <= XFER);
   end

   always @(negedge clk) begin
      checkOutput("hreadyout", 32'(hreadyout), 32'(expReady));
      checkOutput("hresp", 32'(hresp), 32'(expResp));
      checkOutput("spi_cs", 32'(cs), 32'(expCs));
      checkOutput("hrdata", hrdata, expData);
      if (expCs) checkOutput("sclk_idle", 32'(sclk), 32'd0);
   end

   // Drives one address phase at a falling edge, then waits for the data phase to complete.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic fl, output int waits);
      hsel   = 1'b1;
      htrans = 2'b10;
      hwrite = wr;
      haddr  = addr;
      flush  = fl;
      @(posedge clk);
      @(negedge clk);
      hsel   = 1'b0;
      htrans = 2'b00;
      hwrite = 1'b0;
      flush  = 1'b0;
      waits  = 0;
      while (hreadyout !== 1'b1 && waits < 2000) begin
         waits++;
         @(negedge clk);
      end
   endtask

   int w, e0;

   initial begin
      for (int i = 0; i < 256; i++) flashMem[i] = 8'h00;
      flashMem[0] = 8'h11; flashMem[1] = 8'h22; flashMem[2] = 8'h33; flashMem[3] = 8'h44;
      flashMem[4] = 8'h55; flashMem[5] = 8'h66; flashMem[6] = 8'h77; flashMem[7] = 8'h88;
      rst = 1'b1; hsel = 1'b0; hwrite = 1'b0; flush = 1'b0;
      haddr = '0; htrans = 2'b00; hsize = 3'b010;
      repeat (3) @(negedge clk);
      checkOutput("rst_cs", 32'(cs), 32'd1);
      checkOutput("rst_sclk", 32'(sclk), 32'd0);
      checkOutput("rst_mosi", 32'(mosi), 32'd0);
      checkOutput("rst_ready", 32'(hreadyout), 32'd1);
      checkOutput("rst_hresp", 32'(hresp), 32'd0);
      checkOutput("rst_hrdata", hrdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(1'b0, 32'h0000_0100, 1'b0, w);
      checkOutput("miss100_waits", 32'(w), 32'd256);
      checkOutput("miss100_data", hrdata, 32'h4433_2211);
      checkOutput("miss100_cmd", fCmd, 32'h0300_0100);

      e0 = sclkEdges;
      applyStimulus(1'b0, 32'h0000_0102, 1'b0, w);
      checkOutput("hit102_waits", 32'(w), 32'd0);
      checkOutput("hit102_data", hrdata, 32'h4433_2211);
      checkOutput("hit102_sclk", 32'(sclkEdges), 32'(e0));

      // Unselected NONSEQ write must be ignored with an OKAY response.
      hsel = 1'b0; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h100;
      @(negedge clk);
      htrans = 2'b00; hwrite = 1'b0;
      checkOutput("unsel_ready", 32'(hreadyout), 32'd1);
      checkOutput("unsel_hresp", 32'(hresp), 32'd0);
      repeat (4) @(negedge clk);

      applyStimulus(1'b0, 32'h0000_0100, 1'b1, w);
      checkOutput("flushhit_waits", 32'(w), 32'd256);
      applyStimulus(1'b0, 32'h0000_0104, 1'b0, w);
      checkOutput("b2b104_waits", 32'(w), 32'd258);
      checkOutput("b2b104_data", hrdata, 32'h8877_6655);
      checkOutput("b2b104_cmd", fCmd, 32'h0300_0104);
      repeat (3) @(negedge clk);

      e0 = sclkEdges;
      applyStimulus(1'b1, 32'h0000_0100, 1'b0, w);
      checkOutput("write_waits", 32'(w), 32'd1);
      checkOutput("write_hresp2", 32'(hresp), 32'd1);
      @(negedge clk);
      checkOutput("write_after", 32'(hresp), 32'd0);
      checkOutput("write_sclk", 32'(sclkEdges), 32'(e0));
      applyStimulus(1'b0, 32'h0000_0104, 1'b0, w);
      checkOutput("hit104_waits", 32'(w), 32'd0);
      checkOutput("hit104_data", hrdata, 32'h8877_6655);
      repeat (4) @(negedge clk);

      applyStimulus(1'b0, 32'h0000_0104, 1'b1, w);
      checkOutput("flush104_waits", 32'(w), 32'd256);
      checkOutput("flush104_data", hrdata, 32'h8877_6655);
      repeat (4) @(negedge clk);

      // Flush pulse in the middle of a fetch must not stop the word being cached.
      fork
         applyStimulus(1'b0, 32'h0000_0100, 1'b0, w);
         begin
            repeat (50) @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
         end
      join
      checkOutput("midflush_waits", 32'(w), 32'd256);
      applyStimulus(1'b0, 32'h0000_0102, 1'b0, w);
      checkOutput("midflush_hit", 32'(w), 32'd0);
      checkOutput("midflush_data", hrdata, 32'h4433_2211);
      repeat (4) @(negedge clk);

      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h104;
      @(posedge clk);
      @(negedge clk);
      hsel = 1'b0; htrans = 2'b00;
      repeat (99) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_cs", 32'(cs), 32'd1);
      checkOutput("abort_hrdata", hrdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(1'b0, 32'h0000_0104, 1'b0, w);
      checkOutput("postrst_waits", 32'(w), 32'd256);
      checkOutput("postrst_data", hrdata, 32'h8877_6655);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
